// File: rtl/revo_clock_decoder_pkg.sv
// Shared definitions for the revo clock decoder: lock-state encoding,
// default parameter values and the normal-period window.
package revo_clock_decoder_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam int unsigned GAP_WIDTH          = 4;
    localparam int unsigned DEF_NOMINAL_PERIOD = 4;
    localparam int unsigned DEF_PERIOD_TOL     = 1;
    localparam int unsigned DEF_GAP_MIN        = 6;
    localparam int unsigned DEF_GAP_MAX        = 12;
    localparam int unsigned DEF_LOCK_COUNT     = 16;
    localparam int unsigned DEF_STAT_WIDTH     = 16;

    localparam int unsigned DEF_PERIOD_LO = DEF_NOMINAL_PERIOD - DEF_PERIOD_TOL;
    localparam int unsigned DEF_PERIOD_HI = DEF_NOMINAL_PERIOD + DEF_PERIOD_TOL;

    function automatic logic in_window(
        input logic [GAP_WIDTH-1:0] value,
        input logic [GAP_WIDTH-1:0] lo,
        input logic [GAP_WIDTH-1:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/revo_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge strobe (one clk cycle wide).
module revo_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
        end
    end

endmodule

// File: rtl/revo_clock_decoder.sv
// Recovers revo markers (one suppressed encoded-clock cycle) sampled at clock509.
// Define REVO_DECODER_STATS_EN to build the saturating revo/error counters.
module revo_clock_decoder
    import revo_clock_decoder_pkg::*;
#(
    parameter int unsigned NOMINAL_PERIOD = DEF_NOMINAL_PERIOD,
    parameter int unsigned PERIOD_TOL     = DEF_PERIOD_TOL,
    parameter int unsigned GAP_MIN        = DEF_GAP_MIN,
    parameter int unsigned GAP_MAX        = DEF_GAP_MAX,
    parameter int unsigned LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int unsigned STAT_WIDTH     = DEF_STAT_WIDTH
) (
    input  logic                  clock509,
    input  logic                  reset_n,
    input  logic                  encoded_in,
    output logic                  revo,
    output logic                  locked,
    output logic                  loss,
    output logic [1:0]            phase,
    output logic [STAT_WIDTH-1:0] revo_count,
    output logic [STAT_WIDTH-1:0] error_count
);

    localparam int unsigned GOOD_WIDTH = $clog2(LOCK_COUNT + 1);
    localparam logic [GAP_WIDTH-1:0]  PERIOD_LO = GAP_WIDTH'(NOMINAL_PERIOD - PERIOD_TOL);
    localparam logic [GAP_WIDTH-1:0]  PERIOD_HI = GAP_WIDTH'(NOMINAL_PERIOD + PERIOD_TOL);
    localparam logic [GAP_WIDTH-1:0]  GAP_MIN_V = GAP_WIDTH'(GAP_MIN);
    localparam logic [GAP_WIDTH-1:0]  GAP_MAX_V = GAP_WIDTH'(GAP_MAX);
    localparam logic [GOOD_WIDTH-1:0] GOOD_LAST = GOOD_WIDTH'(LOCK_COUNT - 1);

    lock_state_t           state;
    lock_state_t           state_next;
    logic                  strobe;
    logic [GAP_WIDTH-1:0]  gap;
    logic [1:0]            phase_cnt;
    logic [GOOD_WIDTH-1:0] good;
    logic [GOOD_WIDTH-1:0] good_next;
    logic                  period_normal;
    logic                  gap_max_hit;
    logic                  revo_next;
    logic                  loss_next;

    revo_edge_sync u_edge_sync (
        .clk   (clock509),
        .rst_n (reset_n),
        .din   (encoded_in),
        .rise  (strobe)
    );

    assign period_normal = strobe && in_window(gap, PERIOD_LO, PERIOD_HI);
    assign gap_max_hit   = (gap == GAP_MAX_V);

    always_ff @(posedge clock509 or negedge reset_n) begin
        if (!reset_n) state <= UNLOCKED;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            UNLOCKED: if (period_normal && good == GOOD_LAST) state_next = LOCKED;
            LOCKED:   if (gap_max_hit) state_next = UNLOCKED;
            default:  state_next = UNLOCKED;
        endcase
    end

    // An edge strobe in the GAP_MIN cycle means the pulse was late, not missing.
    always_comb begin
        revo_next = 1'b0;
        loss_next = 1'b0;
        good_next = good;
        case (state)
            UNLOCKED: begin
                if (period_normal)
                    good_next = (good == GOOD_LAST) ? '0 : good + 1'b1;
                else if (strobe || gap_max_hit)
                    good_next = '0;
            end
            LOCKED: begin
                revo_next = (gap == GAP_MIN_V) && !strobe;
                loss_next = gap_max_hit;
                good_next = '0;
            end
            default: good_next = '0;
        endcase
    end

    always_ff @(posedge clock509 or negedge reset_n) begin
        if (!reset_n) begin
            gap       <= '0;
            phase_cnt <= '0;
            phase     <= '0;
            good      <= '0;
            revo      <= 1'b0;
            loss      <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (strobe)          gap <= GAP_WIDTH'(1);
            else if (gap != '1)  gap <= gap + 1'b1;
            phase_cnt <= phase_cnt + 1'b1;
            if (strobe) phase <= phase_cnt;
            good   <= good_next;
            revo   <= revo_next;
            loss   <= loss_next;
            locked <= (state_next == LOCKED);
        end
    end

`ifdef REVO_DECODER_STATS_EN
    logic error_event;

    assign error_event = loss_next || (state == LOCKED && strobe && gap < PERIOD_LO);

    always_ff @(posedge clock509 or negedge reset_n) begin
        if (!reset_n) begin
            revo_count  <= '0;
            error_count <= '0;
        end else begin
            if (revo_next && revo_count != '1)    revo_count  <= revo_count + 1'b1;
            if (error_event && error_count != '1) error_count <= error_count + 1'b1;
        end
    end
`else
    assign revo_count  = '0;
    assign error_count = '0;
`endif

endmodule

// File: tb/tb_revo_clock_decoder.sv
// Directed, table-driven bench for revo_clock_decoder; expected counter values
// follow whether REVO_DECODER_STATS_EN is defined.
module tb_revo_clock_decoder;

`ifdef REVO_DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef enum int unsigned {PRE_NONE, PRE_SUPPRESS, PRE_LOW2, PRE_LOW3, PRE_GLITCH} pre_t;

    typedef struct {
        string       name;
        pre_t        pre;
        int unsigned clean;
        bit          exp_locked;
        int unsigned exp_revos;
        int unsigned exp_losses;
        int unsigned exp_errs;
    } vec_t;

    logic        clock509 = 1'b0;
    logic        reset_n;
    logic        encoded_in;
    logic        revo;
    logic        locked;
    logic        loss;
    logic [1:0]  phase;
    logic [15:0] revo_count;
    logic [15:0] error_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned rel_cyc = 0;
    int unsigned last_pin_edge = 0;
    int unsigned revo_pulses = 0;
    int unsigned loss_pulses = 0;
    int unsigned revo_last_cyc = 0;
    int unsigned loss_last_cyc = 0;
    int unsigned revo_wide = 0;
    logic        pin_prev = 1'b0;
    logic        revo_prev = 1'b0;

    revo_clock_decoder #(
        .NOMINAL_PERIOD (4),
        .PERIOD_TOL     (1),
        .GAP_MIN        (6),
        .GAP_MAX        (12),
        .LOCK_COUNT     (16),
        .STAT_WIDTH     (16)
    ) dut (
        .clock509    (clock509),
        .reset_n     (reset_n),
        .encoded_in  (encoded_in),
        .revo        (revo),
        .locked      (locked),
        .loss        (loss),
        .phase       (phase),
        .revo_count  (revo_count),
        .error_count (error_count)
    );

    always #5 clock509 = ~clock509;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock509 cycle: drive the pin, let the edge capture it, observe 1 unit later.
    task automatic tick(input logic v);
        encoded_in = v;
        @(posedge clock509);
        #1;
        cyc++;
        if (v && !pin_prev) last_pin_edge = cyc;
        pin_prev = v;
        if (revo === 1'b1) begin
            revo_pulses++;
            revo_last_cyc = cyc;
            if (revo_prev) revo_wide++;
        end
        revo_prev = (revo === 1'b1);
        if (loss === 1'b1) begin
            loss_pulses++;
            loss_last_cyc = cyc;
        end
    endtask

    task automatic clean_period();
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    endtask

    task automatic low(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_revo"},        32'(revo),        0);
        chk({tag, "_locked"},      32'(locked),      0);
        chk({tag, "_loss"},        32'(loss),        0);
        chk({tag, "_phase"},       32'(phase),       0);
        chk({tag, "_revo_count"},  32'(revo_count),  0);
        chk({tag, "_error_count"}, 32'(error_count), 0);
    endtask

    initial begin
        vec_t        vecs[8];
        int unsigned e;

        vecs[0] = '{"prelock",         PRE_NONE,     12, 1'b0, 0, 0, 0};
        vecs[1] = '{"lock",            PRE_NONE,      8, 1'b1, 0, 0, 0};
        vecs[2] = '{"revo1",           PRE_SUPPRESS, 50, 1'b1, 1, 0, 0};
        vecs[3] = '{"revo2",           PRE_SUPPRESS, 50, 1'b1, 2, 0, 0};
        vecs[4] = '{"revo3",           PRE_SUPPRESS, 50, 1'b1, 3, 0, 0};
        vecs[5] = '{"edge_at_gap_min", PRE_LOW2,      4, 1'b1, 3, 0, 0};
        vecs[6] = '{"glitch",          PRE_GLITCH,    4, 1'b1, 3, 0, 1};
        vecs[7] = '{"period7",         PRE_LOW3,      4, 1'b1, 4, 0, 1};

        reset_n    = 1'b0;
        encoded_in = 1'b0;
        low(3);
        chk_reset_state("reset");

        reset_n = 1'b1;
        rel_cyc = cyc;
        low(4);

        for (int unsigned i = 0; i < 8; i++) begin
            case (vecs[i].pre)
                PRE_SUPPRESS: low(4);
                PRE_LOW2:     low(2);
                PRE_LOW3:     low(3);
                PRE_GLITCH:   begin tick(1'b1); tick(1'b0); end
                default:      ;
            endcase
            for (int unsigned k = 0; k < vecs[i].clean; k++) clean_period();
            chk({vecs[i].name, "_locked"},      32'(locked),      32'(vecs[i].exp_locked));
            chk({vecs[i].name, "_revo_pulses"}, revo_pulses,      vecs[i].exp_revos);
            chk({vecs[i].name, "_loss_pulses"}, loss_pulses,      vecs[i].exp_losses);
            chk({vecs[i].name, "_revo_count"},  32'(revo_count),  STATS ? vecs[i].exp_revos : 0);
            chk({vecs[i].name, "_error_count"}, 32'(error_count), STATS ? vecs[i].exp_errs : 0);
            chk({vecs[i].name, "_phase"},       32'(phase),       (last_pin_edge + 2 - rel_cyc) % 4);
        end

        // Revo latency from the last real pin edge before a suppressed cycle.
        clean_period();
        e = last_pin_edge;
        low(4);
        repeat (3) clean_period();
        chk("revo_latency",      revo_last_cyc - e, 9);
        chk("revo_pulses_h1",    revo_pulses,       5);
        chk("revo_single_cycle", revo_wide,         0);
        chk("revo_count_h1",     32'(revo_count),   STATS ? 5 : 0);
        chk("locked_h1",         32'(locked),       1);

        // Line dropped for 20 cycles: revo at gap 6, then loss at gap 12.
        clean_period();
        e = last_pin_edge;
        low(20);
        chk("loss_latency",     loss_last_cyc - e, 15);
        chk("loss_pulses",      loss_pulses,       1);
        chk("drop_locked",      32'(locked),       0);
        chk("drop_error_count", 32'(error_count),  STATS ? 2 : 0);
        chk("drop_revo_pulses", revo_pulses,       6);

        // Relock: first edge after the drop is abnormal, then 16 normal periods.
        repeat (16) clean_period();
        chk("relock_15_normal", 32'(locked), 0);
        tick(1'b1); tick(1'b1); tick(1'b0);
        chk("relock_pre",  32'(locked), 0);
        tick(1'b0);
        chk("relock_edge", 32'(locked), 1);
        chk("relock_error_count", 32'(error_count), STATS ? 2 : 0);

        // Reset dropped in the cycle before revo would register.
        clean_period();
        low(5);
        reset_n = 1'b0;
        tick(1'b0);
        chk_reset_state("midreset");
        chk("midreset_no_revo", revo_pulses, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
